axis_median3x3_stream: RTL and testbench

Streaming 3×3 median (salt-and-pepper) filter with AXI-Stream slave input and master output, parametrised in image rows, columns and pixel width. It buffers two image lines plus a 3×3 window, so frames of any size stream through without a whole-frame buffer. It sits between the UART-to-AXIS receiver and the AXIS-to-UART transmitter in the image-processing system. It processes back-to-back raster-order frames with full backpressure support.

---
 rtl/axis_median3x3_stream_if.sv | 24 ++
 rtl/axis_median3x3_stream.sv | 196 +++++++++++++++++++
 tb/tb_axis_median3x3_stream.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_median3x3_stream_if.sv
// AXI-Stream pixel channel shared by the median filter input and output.
// The master drives data/valid/last; the slave drives ready.
interface axis_median3x3_stream_if #(
    parameter int W = 8
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_median3x3_stream.sv
// axis_median3x3_stream: streaming 3x3 median filter, two line buffers + window.
// Define SP_DETECT_EN to filter only salt/pepper (0 or max) interior pixels.
module axis_median3x3_stream #(
    parameter int R_I = 7,
    parameter int C_I = 7,
    parameter int W_I = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    axis_median3x3_stream_if.slave  s_axis,
    axis_median3x3_stream_if.master m_axis,
    output logic                    busy,
    output logic                    frame_err
);
    localparam int NPIX  = R_I * C_I;
    localparam int NSTEP = NPIX + C_I + 1;
    localparam int NW    = $clog2(NSTEP);
    localparam int RW    = $clog2(R_I);
    localparam int CW    = $clog2(C_I);

    localparam logic [NW-1:0]  FILL_END  = NW'(C_I);
    localparam logic [NW-1:0]  RUN_END   = NW'(NPIX - 1);
    localparam logic [NW-1:0]  FLUSH_END = NW'(NSTEP - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(R_I - 1);
    localparam logic [CW-1:0]  COL_LAST  = CW'(C_I - 1);
    localparam logic [W_I-1:0] PIX_MAX   = '1;

    // Compare-exchange pairs of a 19-element median-of-9 network
    localparam int SA [19] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0,
                               5, 4, 3, 1, 2, 4, 4, 6, 4};
    localparam int SB [19] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3,
                               8, 7, 6, 4, 5, 7, 2, 4, 2};

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

    state_t                    state_q, state_d;
    logic [NW-1:0]             n_q, n_d;
    logic [CW-1:0]             ptr_q, ptr_d;
    logic [RW-1:0]             row_q, row_d;
    logic [CW-1:0]             col_q, col_d;
    logic [2:0][1:0][W_I-1:0]  win_q, win_d;
    logic [W_I-1:0]            tdata_q, tdata_d;
    logic                      tlast_q, tlast_d;
    logic                      tvalid_q, tvalid_d;
    logic                      err_q, err_d;

    logic [W_I-1:0]            lb1_q [C_I];
    logic [W_I-1:0]            lb2_q [C_I];

    logic                      out_free;
    logic                      step;
    logic                      emit;
    logic                      take;
    logic [W_I-1:0]            pin;
    logic [2:0][W_I-1:0]       col_new;
    logic [8:0][W_I-1:0]       win9;
    logic [W_I-1:0]            centre;
    logic [W_I-1:0]            med;
    logic                      border;
    logic                      use_med;
    logic [W_I-1:0]            pout;

    function automatic logic [W_I-1:0] med9(input logic [8:0][W_I-1:0] v_in);
        logic [8:0][W_I-1:0] v;
        logic [W_I-1:0]      t;
        v = v_in;
        for (int i = 0; i < 19; i++) begin
            if (v[SA[i]] > v[SB[i]]) begin
                t        = v[SA[i]];
                v[SA[i]] = v[SB[i]];
                v[SB[i]] = t;
            end
        end
        return v[4];
    endfunction

    always_comb begin
        out_free = !tvalid_q || m_axis.tready;
        step     = out_free && (state_q == FLUSH || s_axis.tvalid);
        emit     = step && (state_q != FILL);
        take     = step && (state_q != FLUSH);
        pin      = (state_q == FLUSH) ? '0 : s_axis.tdata;
    end

    // New column: rows n-2C, n-C, n; window registers hold columns n-1, n-2
    always_comb begin
        col_new = {pin, lb1_q[ptr_q], lb2_q[ptr_q]};
        win9    = {win_q[0][1], win_q[0][0], col_new[0],
                   win_q[1][1], win_q[1][0], col_new[1],
                   win_q[2][1], win_q[2][0], col_new[2]};
        centre  = win_q[1][0];
        med     = med9(win9);
        border  = (row_q == '0) || (row_q == ROW_LAST) ||
                  (col_q == '0) || (col_q == COL_LAST);
`ifdef SP_DETECT_EN
        use_med = !border && (centre == '0 || centre == PIX_MAX);
`else
        use_med = !border;
`endif
        pout    = use_med ? med : centre;
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        ptr_d    = ptr_q;
        row_d    = row_q;
        col_d    = col_q;
        win_d    = win_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        err_d    = err_q;

        if (step) begin
            n_d   = n_q + 1'b1;
            ptr_d = (ptr_q == COL_LAST) ? '0 : ptr_q + 1'b1;
            for (int r = 0; r < 3; r++) begin
                win_d[r][1] = win_q[r][0];
                win_d[r][0] = col_new[r];
            end
            unique case (state_q)
                FILL:    if (n_q == FILL_END) state_d = RUN;
                RUN:     if (n_q == RUN_END) state_d = FLUSH;
                FLUSH: begin
                    if (n_q == FLUSH_END) begin
                        state_d = FILL;
                        n_d     = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        if (emit) begin
            tdata_d = pout;
            tlast_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (out_free) tvalid_d = emit;

        if (take && (s_axis.tlast != (n_q == RUN_END))) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= FILL;
            n_q      <= '0;
            ptr_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            win_q    <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            ptr_q    <= ptr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            win_q    <= win_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            err_q    <= err_d;
        end
    end

    // Line buffers are C_I-step delay lines; contents need no reset
    always_ff @(posedge clk) begin
        if (step) begin
            lb1_q[ptr_q] <= pin;
            lb2_q[ptr_q] <= lb1_q[ptr_q];
        end
    end

    assign s_axis.tready = rstn && out_free && (state_q != FLUSH);
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = (state_q == RUN) || (state_q == FLUSH);
    assign frame_err     = err_q;

endmodule

// File: tb/tb_axis_median3x3_stream.sv
// tb_axis_median3x3_stream: randomized frames checked against a 2-D median model.
// Build with or without SP_DETECT_EN to match the design.
module tb_axis_median3x3_stream;
    localparam int R = 7;
    localparam int C = 7;
    localparam int N = R * C;

    logic clk;
    logic rstn;
    logic busy;
    logic frame_err;
    int   total;
    int   bad;
    int   cyc;

    axis_median3x3_stream_if #(.W(8)) s_if ();
    axis_median3x3_stream_if #(.W(8)) m_if ();

    axis_median3x3_stream #(.R_I(R), .C_I(C), .W_I(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] in_d[$];
    logic       in_l[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic [7:0] obs_d[$];
    logic       obs_l[$];
    int         obs_c[$];
    int         acc_c[$];
    int         hold_viol;
    int         first_err;

    task automatic fill_frame(input int nfr, input int val);
        in_d.delete();
        in_l.delete();
        for (int i = 0; i < nfr * N; i++) begin
            in_d.push_back(8'(val));
            in_l.push_back((i % N) == N - 1);
        end
    endtask

    // Reference: full-frame neighbourhoods, median by sorting nine values
    task automatic model(input int nfr);
        exp_d.delete();
        exp_l.delete();
        for (int f = 0; f < nfr; f++) begin
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    int base;
                    int ctr;
                    int e;
                    int nb[9];
                    int m;
                    int t;
                    base = f * N;
                    ctr  = int'(in_d[base + r * C + c]);
                    e    = ctr;
                    if (r > 0 && r < R - 1 && c > 0 && c < C - 1) begin
                        m = 0;
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++) begin
                                nb[m] = int'(in_d[base + (r + dr) * C + c + dc]);
                                m++;
                            end
                        for (int i = 0; i < 9; i++)
                            for (int j = 0; j < 8 - i; j++)
                                if (nb[j] > nb[j + 1]) begin
                                    t = nb[j]; nb[j] = nb[j + 1]; nb[j + 1] = t;
                                end
`ifdef SP_DETECT_EN
                        if (ctr == 0 || ctr == 255) e = nb[4];
`else
                        e = nb[4];
`endif
                    end
                    exp_d.push_back(8'(e));
                    exp_l.push_back(r == R - 1 && c == C - 1);
                end
            end
        end
    endtask

    task automatic drive(input int vprob);
        int i;
        int guard;
        i = 0;
        guard = 0;
        acc_c.delete();
        while (i < in_d.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
            s_if.tvalid = ($urandom_range(0, 99) < vprob);
            s_if.tdata  = in_d[i];
            s_if.tlast  = in_l[i];
            #1;
            if (s_if.tvalid && s_if.tready) begin
                acc_c.push_back(cyc);
                i++;
            end
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        if (i < in_d.size()) begin
            total++; bad++;
            $display("FAIL drive_timeout accepted=%0d wanted=%0d", i, in_d.size());
        end
    endtask

    task automatic collect(input int n, input int rmode);
        int   guard;
        int   k;
        logic pv;
        logic pr;
        logic pl;
        logic [7:0] pd;
        logic pat[5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        guard = 0; k = 0; pv = 0; pr = 1; pl = 0; pd = '0;
        obs_d.delete(); obs_l.delete(); obs_c.delete();
        hold_viol = 0;
        first_err = -1;
        while (obs_d.size() < n && guard < 4000) begin
            @(negedge clk);
            guard++;
            case (rmode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = pat[k % 5];
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
            k++;
            #1;
            if (pv && !pr &&
                (!m_if.tvalid || m_if.tdata !== pd || m_if.tlast !== pl))
                hold_viol++;
            if (m_if.tvalid && !m_if.tready && s_if.tready) hold_viol++;
            if (first_err < 0 && frame_err) first_err = cyc;
            if (m_if.tvalid && m_if.tready) begin
                obs_d.push_back(m_if.tdata);
                obs_l.push_back(m_if.tlast);
                obs_c.push_back(cyc);
            end
            pv = m_if.tvalid; pr = m_if.tready;
            pd = m_if.tdata;  pl = m_if.tlast;
        end
        m_if.tready = 1'b1;
        if (obs_d.size() < n) begin
            total++; bad++;
            $display("FAIL collect_timeout got=%0d wanted=%0d", obs_d.size(), n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total += 6;
        if (s_if.tready !== 1'b0) begin bad++; $display("FAIL rst_s_tready got=%b want=0", s_if.tready); end
        if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid got=%b want=0", m_if.tvalid); end
        if (m_if.tdata !== 8'd0) begin bad++; $display("FAIL rst_m_tdata got=%0d want=0", m_if.tdata); end
        if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL rst_m_tlast got=%b want=0", m_if.tlast); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b want=0", frame_err); end
        rstn = 1'b1;
        #1;
        total++;
        if (s_if.tready !== 1'b1) begin bad++; $display("FAIL rst_release_tready got=%b want=1", s_if.tready); end
    endtask

    task automatic test_uniform();
        fill_frame(1, 100);
        in_d[3 * C + 3] = 8'd255;
        in_d[2 * C + 5] = 8'd0;
        model(1);
        fork
            drive(100);
            collect(N, 0);
        join
        total += 4;
        if (obs_d.size() !== N) begin bad++; $display("FAIL uni_count got=%0d want=%0d", obs_d.size(), N); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL uni_frame_err got=%b want=0", frame_err); end
        if (obs_d.size() == N && obs_c[N - 1] - obs_c[0] !== N - 1) begin
            bad++; $display("FAIL uni_throughput got=%0d want=%0d", obs_c[N - 1] - obs_c[0], N - 1);
        end
        if (obs_d.size() == N && acc_c.size() == N && obs_c[0] !== acc_c[C + 1] + 1) begin
            bad++; $display("FAIL uni_latency got=%0d want=%0d", obs_c[0], acc_c[C + 1] + 1);
        end
        for (int i = 0; i < obs_d.size() && i < N; i++) begin
            total += 2;
            if (obs_d[i] !== 8'd100) begin bad++; $display("FAIL uni_data idx=%0d got=%0d want=100", i, obs_d[i]); end
            if (obs_l[i] !== (i == N - 1)) begin bad++; $display("FAIL uni_tlast idx=%0d got=%b want=%b", i, obs_l[i], i == N - 1); end
        end
    endtask

    task automatic test_border();
        fill_frame(1, 50);
        in_d[0] = 8'd255;
        in_d[6 * C + 3] = 8'd255;
        fork
            drive(100);
            collect(N, 0);
        join
        total++;
        if (obs_d.size() !== N) begin bad++; $display("FAIL border_count got=%0d want=%0d", obs_d.size(), N); end
        for (int i = 0; i < obs_d.size() && i < N; i++) begin
            logic [7:0] want;
            want = (i == 0 || i == 6 * C + 3) ? 8'd255 : 8'd50;
            total++;
            if (obs_d[i] !== want) begin bad++; $display("FAIL border_data idx=%0d got=%0d want=%0d", i, obs_d[i], want); end
        end
    endtask

    task automatic test_backpressure();
        fill_frame(1, 0);
        for (int i = 0; i < N; i++) in_d[i] = 8'(i);
        model(1);
        fork
            drive(100);
            collect(N, 1);
        join
        total += 2;
        if (obs_d.size() !== N) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_d.size(), N); end
        if (hold_viol !== 0) begin bad++; $display("FAIL bp_hold got=%0d violations want=0", hold_viol); end
        for (int i = 0; i < obs_d.size() && i < N; i++) begin
            total++;
            if (obs_d[i] !== exp_d[i]) begin bad++; $display("FAIL bp_data idx=%0d got=%0d want=%0d", i, obs_d[i], exp_d[i]); end
        end
    endtask

    task automatic test_mode();
        logic [7:0] want;
        fill_frame(1, 10);
        in_d[3 * C + 3] = 8'd120;
`ifdef SP_DETECT_EN
        want = 8'd120;
`else
        want = 8'd10;
`endif
        fork
            drive(100);
            collect(N, 0);
        join
        total++;
        if (obs_d.size() !== N) begin bad++; $display("FAIL mode_count got=%0d want=%0d", obs_d.size(), N); end
        for (int i = 0; i < obs_d.size() && i < N; i++) begin
            total++;
            if (i == 3 * C + 3) begin
                if (obs_d[i] !== want) begin bad++; $display("FAIL mode_centre got=%0d want=%0d", obs_d[i], want); end
            end else if (obs_d[i] !== 8'd10) begin
                bad++; $display("FAIL mode_data idx=%0d got=%0d want=10", i, obs_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_frame(2, 0);
        for (int i = 0; i < 2 * N; i++) in_d[i] = 8'($urandom_range(0, 255));
        model(2);
        fork
            drive(100);
            collect(2 * N, 0);
        join
        total += 2;
        if (obs_d.size() !== 2 * N) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_d.size(), 2 * N); end
        if (acc_c.size() == 2 * N && acc_c[N] - acc_c[N - 1] - 1 !== C + 1) begin
            bad++; $display("FAIL b2b_gap got=%0d want=%0d", acc_c[N] - acc_c[N - 1] - 1, C + 1);
        end
        for (int i = 0; i < obs_d.size() && i < 2 * N; i++) begin
            total += 2;
            if (obs_d[i] !== exp_d[i]) begin bad++; $display("FAIL b2b_data idx=%0d got=%0d want=%0d", i, obs_d[i], exp_d[i]); end
            if (obs_l[i] !== exp_l[i]) begin bad++; $display("FAIL b2b_tlast idx=%0d got=%b want=%b", i, obs_l[i], exp_l[i]); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            fill_frame(1, 0);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       in_d[i] = 8'd0;
                    1:       in_d[i] = 8'd255;
                    default: in_d[i] = 8'($urandom_range(0, 255));
                endcase
            end
            model(1);
            fork
                drive(60);
                collect(N, 2);
            join
            total += 2;
            if (obs_d.size() !== N) begin bad++; $display("FAIL rnd_count f=%0d got=%0d want=%0d", f, obs_d.size(), N); end
            if (hold_viol !== 0) begin bad++; $display("FAIL rnd_hold f=%0d got=%0d want=0", f, hold_viol); end
            for (int i = 0; i < obs_d.size() && i < N; i++) begin
                total++;
                if (obs_d[i] !== exp_d[i]) begin bad++; $display("FAIL rnd_data f=%0d idx=%0d got=%0d want=%0d", f, i, obs_d[i], exp_d[i]); end
            end
        end
    endtask

    task automatic test_frame_err();
        fill_frame(1, 77);
        in_l[20] = 1'b1;
        in_l[N - 1] = 1'b0;
        fork
            drive(100);
            collect(N, 0);
        join
        total += 4;
        if (obs_d.size() !== N) begin bad++; $display("FAIL ferr_count got=%0d want=%0d", obs_d.size(), N); end
        if (acc_c.size() == N && first_err !== acc_c[20] + 1) begin
            bad++; $display("FAIL ferr_rise got=%0d want=%0d", first_err, acc_c[20] + 1);
        end
        if (obs_l.size() == N && obs_l[N - 1] !== 1'b1) begin bad++; $display("FAIL ferr_tlast got=%b want=1", obs_l[N - 1]); end
        repeat (5) @(negedge clk);
        if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_sticky got=%b want=1", frame_err); end
    endtask

    task automatic test_reset_mid();
        int extra;
        fill_frame(1, 33);
        in_d = in_d[0:24];
        m_if.tready = 1'b1;
        drive(100);
        rstn = 1'b0;
        #1;
        total += 6;
        if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL mid_tvalid got=%b want=0", m_if.tvalid); end
        if (m_if.tdata !== 8'd0) begin bad++; $display("FAIL mid_tdata got=%0d want=0", m_if.tdata); end
        if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL mid_tlast got=%b want=0", m_if.tlast); end
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_frame_err got=%b want=0", frame_err); end
        if (s_if.tready !== 1'b0) begin bad++; $display("FAIL mid_s_tready got=%b want=0", s_if.tready); end
        @(negedge clk);
        rstn = 1'b1;
        fill_frame(1, 100);
        fork
            drive(100);
            collect(N, 0);
        join
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_if.tvalid) extra++;
        end
        total += 2;
        if (obs_d.size() !== N) begin bad++; $display("FAIL mid_count got=%0d want=%0d", obs_d.size(), N); end
        if (extra !== 0) begin bad++; $display("FAIL mid_extra got=%0d want=0", extra); end
        for (int i = 0; i < obs_d.size() && i < N; i++) begin
            total++;
            if (obs_d[i] !== 8'd100) begin bad++; $display("FAIL mid_data idx=%0d got=%0d want=100", i, obs_d[i]); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rstn = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        test_reset();
        test_uniform();
        test_border();
        test_backpressure();
        test_mode();
        test_back_to_back();
        test_random();
        test_frame_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
